// File: rtl/ledmux_pkg.sv
// Shared LED-mux definitions: display mode encodings and a small sizing helper.
package ledmux_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_OFF   = 3'd0;
    localparam logic [MODE_W-1:0] MODE_ON    = 3'd1;
    localparam logic [MODE_W-1:0] MODE_CODE  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_SCORE = 3'd3;
    localparam logic [MODE_W-1:0] MODE_BLINK = 3'd4;
    localparam logic [MODE_W-1:0] MODE_CHASE = 3'd5;
    localparam logic [MODE_W-1:0] MODE_FLASH = 3'd6;
    localparam logic [MODE_W-1:0] MODE_FILL  = 3'd7;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: pulses tick for one cycle every DIV clocks; clear restarts the count.
module tick_gen #(
    parameter int unsigned DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Registered LED pattern driver: static patterns plus tick-timed blink/chase/flash/fill animations.
module led_pattern_ctrl
    import ledmux_pkg::*;
#(
    parameter int unsigned WIDTH       = 7,
    parameter int unsigned TICK_DIV    = 12_500_000,
    parameter int unsigned FLASH_COUNT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] score,
    output logic [WIDTH-1:0] leds_out,
    output logic             anim_done
);

    localparam int unsigned FLASH_END = 2 * FLASH_COUNT;
    localparam int unsigned PH_MAX    = max_u(WIDTH, FLASH_END + 1);
    localparam int unsigned PH_W      = $clog2(PH_MAX);

    logic [MODE_W-1:0] mode_q;
    logic [PH_W-1:0]   phase_q;
    logic [PH_W-1:0]   phase_d;
    logic [WIDTH-1:0]  leds_q;
    logic [WIDTH-1:0]  leds_d;
    logic              done_q;
    logic              done_d;
    logic              mode_chg;
    logic              tick;

    assign mode_chg = (mode != mode_q);

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (mode_chg),
        .tick  (tick)
    );

    // Phase sequencing; a mode change wins over a coincident tick.
    always_comb begin
        phase_d = phase_q;
        if (mode_chg) begin
            phase_d = '0;
        end else if (tick) begin
            case (mode_q)
                MODE_BLINK: phase_d = phase_q ^ PH_W'(1);
                MODE_CHASE,
                MODE_FILL:  phase_d = (phase_q == PH_W'(WIDTH - 1)) ? '0 : phase_q + PH_W'(1);
                MODE_FLASH: begin
                    if (phase_q != PH_W'(FLASH_END)) begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
                default:    phase_d = phase_q;
            endcase
        end
    end

    // Pattern decode from the stored mode and current phase.
    always_comb begin
        leds_d = '0;
        done_d = 1'b0;
        case (mode_q)
            MODE_OFF:   leds_d = '0;
            MODE_ON:    leds_d = '1;
            MODE_CODE: begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    leds_d[i] = ((i % 3) == 0);
                end
            end
            MODE_SCORE: leds_d = score;
            MODE_BLINK: leds_d = phase_q[0] ? '0 : score;
            MODE_CHASE: begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    leds_d[i] = (PH_W'(i) == phase_q);
                end
            end
            MODE_FLASH: begin
                if (phase_q == PH_W'(FLASH_END)) begin
                    leds_d = score;
                    done_d = 1'b1;
                end else begin
                    leds_d = phase_q[0] ? '0 : '1;
                end
            end
            MODE_FILL: begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    leds_d[i] = (PH_W'(i) <= phase_q);
                end
            end
            default:    leds_d = '0;
        endcase
        if (mode_chg) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q  <= '0;
            phase_q <= '0;
            leds_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            mode_q  <= mode;
            phase_q <= phase_d;
            leds_q  <= leds_d;
            done_q  <= done_d;
        end
    end

    assign leds_out  = leds_q;
    assign anim_done = done_q;

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Registered, parametrised LED driver for the Tug of War board: selects one of eight display patterns for a WIDTH-bit LED bank, including timed animations (blink, chase, win-flash, fill bar) clocked by an internal prescaler. Sits between the game controller (which supplies `mode` and `score`) and the LED pins, and replaces the purely combinational LED selector with a 3-bit mode set.

## Interface
- `WIDTH`, 7, number of LEDs driven (≥2).
- `TICK_DIV`, 12_500_000, clk cycles per animation tick (≥2; 4 Hz at 50 MHz).
- `FLASH_COUNT`, 3, on/off flash pairs in FLASH mode before holding the score (≥1).

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `mode`  in  3  pattern select (level, sampled every cycle).
- `score`  in  WIDTH  score/position bitmap from game logic.
- `leds_out`  out  WIDTH  registered LED drive, 1 = lit.
- `anim_done`  out  1  high while FLASH mode has completed its flash sequence.

## Operation
- Reset (`rst_n`=0 at an edge): `leds_out`=0, `anim_done`=0, stored mode `mode_q`=0, prescaler=0, `phase`=0. Reset mid-animation abandons it; no state survives.
- Prescaler counts 0..TICK_DIV-1, wraps; `tick` is asserted in the cycle the count equals TICK_DIV-1.
- Mode change: if `mode`≠`mode_q`, then `mode_q`←`mode`, prescaler←0, `phase`←0, `anim_done`←0; this change has priority over any simultaneous tick.
- `phase` advances only on `tick` (and only in modes 4–7); width = clog2 of max(WIDTH, 2·FLASH_COUNT+1).
- Patterns, by `mode_q` and `phase`:
  - 0 OFF: all 0.
  - 1 ON: all 1.
  - 2 CODE: bit i = 1 iff i mod 3 = 0 (WIDTH=7 → 1001001).
  - 3 SCORE: `score`.
  - 4 BLINK: `score` when phase[0]=0, else 0; phase toggles per tick.
  - 5 CHASE: one-hot, bit `phase` lit; phase 0..WIDTH-1, wraps WIDTH-1→0.
  - 6 FLASH: all 1 on even phase, all 0 on odd phase; phase increments per tick until 2·FLASH_COUNT, then freezes; at freeze output = `score` and `anim_done`=1 until mode changes or reset.
  - 7 FILL: low (phase+1) bits lit; phase 0..WIDTH-1, wraps to 1 lit LED after all lit.
- `score` is live in modes 3, 4 and frozen FLASH: score changes appear without restarting the animation.
- Out-of-range values cannot occur (3-bit mode fully decoded).

## Timing
- `leds_out` and `anim_done` are registered: a pattern computed from `mode`/`score`/`phase` at edge N appears after edge N+1 (one-cycle latency).
- Mode change at edge E: pattern for phase 0 of the new mode visible after E+1.
- First tick after a mode change occurs TICK_DIV cycles after E; phase 1 pattern visible one cycle later.
- FLASH: `anim_done` rises on the same cycle `leds_out` first shows `score`, i.e. 2·FLASH_COUNT·TICK_DIV+1 cycles after mode entry.
- Re-selecting the same mode causes no restart; only a value change does.

## Structure
- Shared package `ledmux_pkg`: mode localparams `MODE_OFF`=0, `MODE_ON`=1, `MODE_CODE`=2, `MODE_SCORE`=3, `MODE_BLINK`=4, `MODE_CHASE`=5, `MODE_FLASH`=6, `MODE_FILL`=7; also used by the game controller.
- One sub-module: `tick_gen` (parameter DIV; inputs clk, rst_n, clear; output tick) — the prescaler, reusable for the game's debounce/timeout logic.
- Top contains mode register, phase counter, pattern decode, output registers.

## Test plan
(Bench uses WIDTH=7, TICK_DIV=4, FLASH_COUNT=2.)
- Reset held 3 cycles with mode=1 → `leds_out`=0000000, `anim_done`=0; release → 1111111 one cycle after first unreset edge.
- mode=2 → 1001001; mode=3, score=0010100 → 0010100 next cycle; score→0001000 → follows one cycle later.
- mode=5 → 0000001, then 0000010, … 1000000, 0000001 with each step 4 cycles apart (wrap check).
- mode=6, score=0001000 → 1111111, 0000000, 1111111, 0000000 (4 cycles each), then 0001000 with `anim_done`=1 held; switch to mode=3 → `anim_done`=0 next cycle.
- mode=7 → 0000001, 0000011 … 1111111, 0000001; mode changed to 4 on the same cycle as a tick → phase restarts at 0 (score shown), first blink-off 4 cycles later.
- Reset asserted mid-FLASH (phase 2) → outputs 0, after release with mode=6 the sequence restarts from 1111111.
